// File: rtl/aura_pe_stream.sv
// Streaming FlashAttention PE: one query row against a framed (K,V) stream with online
// softmax (power-of-two weights), then per-element restoring division of o by l.
module aura_pe_stream #(
    parameter int DIM         = 16,
    parameter int DATA_W      = 8,
    parameter int FRAC_W      = 8,
    parameter int SCORE_SHIFT = 0,
    parameter int ACC_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  q_valid,
    output logic                  q_ready,
    input  logic [DIM*DATA_W-1:0] q_vec,
    input  logic                  kv_valid,
    output logic                  kv_ready,
    input  logic                  kv_last,
    input  logic [DIM*DATA_W-1:0] k_vec,
    input  logic [DIM*DATA_W-1:0] v_vec,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIM*DATA_W-1:0] out_vec,
    output logic                  busy
);
    localparam int SW = 2*DATA_W + $clog2(DIM);
    localparam int IW = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int CW = ACC_W + DATA_W + 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCUM  = 2'd1;
    localparam logic [1:0] S_DIVIDE = 2'd2;
    localparam logic [1:0] S_OUTPUT = 2'd3;

    localparam logic [FRAC_W:0]  W_ONE     = {1'b1, {FRAC_W{1'b0}}};
    localparam logic [ACC_W-1:0] L_ONE     = ACC_W'(W_ONE);
    localparam logic [BW-1:0]    BIT_LAST  = BW'(DATA_W-1);
    localparam logic [IW-1:0]    ELEM_LAST = IW'(DIM-1);

    function automatic logic signed [SW-1:0] dot_fn(input logic [DIM*DATA_W-1:0] a,
                                                    input logic [DIM*DATA_W-1:0] b);
        logic signed [SW-1:0] acc, ae, be;
        acc = '0;
        for (int i = 0; i < DIM; i++) begin
            ae  = SW'($signed(a[i*DATA_W +: DATA_W]));
            be  = SW'($signed(b[i*DATA_W +: DATA_W]));
            acc = acc + ae * be;
        end
        return acc;
    endfunction

    // Shifts of ACC_W or more collapse to the sign fill (0 or -1).
    function automatic logic signed [ACC_W-1:0] asr_sat(input logic signed [ACC_W-1:0] x,
                                                        input logic [SW:0] d);
        if (d >= (SW+1)'(ACC_W)) return x >>> (ACC_W-1);
        return x >>> d;
    endfunction

    function automatic logic [ACC_W-1:0] lsr_sat(input logic [ACC_W-1:0] x, input logic [SW:0] d);
        return (d >= (SW+1)'(ACC_W)) ? '0 : x >> d;
    endfunction

    function automatic logic signed [DATA_W-1:0] sat_fn(input logic [DATA_W-1:0] quo,
                                                       input logic ovf, input logic neg);
        logic [DATA_W-1:0] mag;
        mag = (ovf || quo[DATA_W-1]) ? {1'b0, {(DATA_W-1){1'b1}}} : quo;
        return neg ? -mag : mag;
    endfunction

    logic [1:0]               state_q, state_d;
    logic [DIM*DATA_W-1:0]    qv_q, qv_d;
    logic signed [SW-1:0]     m_q, m_d;
    logic [ACC_W-1:0]         l_q, l_d;
    logic signed [ACC_W-1:0]  o_q [DIM];
    logic signed [ACC_W-1:0]  o_d [DIM];
    logic                     have_q, have_d;
    logic                     prep_q, prep_d;
    logic [IW-1:0]            elem_q, elem_d;
    logic [BW-1:0]            bit_q, bit_d;
    logic [ACC_W-1:0]         rem_q, rem_d;
    logic [DATA_W-1:0]        quo_q, quo_d;
    logic                     ovf_q, ovf_d;
    logic [DIM*DATA_W-1:0]    out_q, out_d;

    logic signed [SW-1:0]     score;
    logic signed [SW:0]       diff;
    logic [SW:0]              dmag;
    logic                     gt;
    logic [FRAC_W:0]          wt;
    logic signed [ACC_W-1:0]  o_upd [DIM];
    logic [ACC_W-1:0]         l_upd;

    // Online-softmax update for the pair presented on k_vec/v_vec.
    always_comb begin
        score = dot_fn(qv_q, k_vec) >>> SCORE_SHIFT;
        diff  = (SW+1)'(score) - (SW+1)'(m_q);
        gt    = !diff[SW] && (diff != '0);
        dmag  = gt ? diff : -diff;
        wt    = (dmag > (SW+1)'(FRAC_W)) ? '0 : W_ONE >> dmag;
        if (!have_q)  l_upd = L_ONE;
        else if (gt)  l_upd = lsr_sat(l_q, dmag) + L_ONE;
        else          l_upd = l_q + ACC_W'(wt);
        for (int i = 0; i < DIM; i++) begin
            if (!have_q)
                o_upd[i] = ACC_W'($signed(v_vec[i*DATA_W +: DATA_W])) <<< FRAC_W;
            else if (gt)
                o_upd[i] = asr_sat(o_q[i], dmag)
                         + (ACC_W'($signed(v_vec[i*DATA_W +: DATA_W])) <<< FRAC_W);
            else
                o_upd[i] = o_q[i] + $signed(ACC_W'(wt))
                         * ACC_W'($signed(v_vec[i*DATA_W +: DATA_W]));
        end
    end

    logic [ACC_W-1:0] rem_in;
    logic             ovf_cur, take, neg;
    logic [BW-1:0]    j;
    logic [CW-1:0]    dv;
    logic [ACC_W-1:0] rem_nxt;
    logic [DATA_W-1:0] quo_nxt;

    // One restoring quotient bit per cycle; magnitude loaded on the first bit of each element.
    always_comb begin
        neg     = o_q[elem_q][ACC_W-1];
        rem_in  = (bit_q == '0) ? (neg ? ACC_W'(-o_q[elem_q]) : ACC_W'(o_q[elem_q])) : rem_q;
        ovf_cur = (bit_q == '0) ? (CW'(rem_in) >= {1'b0, l_q, {DATA_W{1'b0}}}) : ovf_q;
        j       = BIT_LAST - bit_q;
        dv      = CW'(l_q) << j;
        take    = CW'(rem_in) >= dv;
        rem_nxt = take ? ACC_W'(CW'(rem_in) - dv) : rem_in;
        quo_nxt = {quo_q[DATA_W-2:0], take};
    end

    always_comb begin
        state_d = state_q;
        qv_d    = qv_q;
        m_d     = m_q;
        l_d     = l_q;
        o_d     = o_q;
        have_d  = have_q;
        prep_d  = prep_q;
        elem_d  = elem_q;
        bit_d   = bit_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        ovf_d   = ovf_q;
        out_d   = out_q;
        case (state_q)
            S_IDLE: if (q_valid) begin
                qv_d    = q_vec;
                have_d  = 1'b0;
                state_d = S_ACCUM;
            end
            S_ACCUM: if (kv_valid) begin
                have_d = 1'b1;
                m_d    = (!have_q || gt) ? score : m_q;
                l_d    = l_upd;
                o_d    = o_upd;
                if (kv_last) begin
                    state_d = S_DIVIDE;
                    prep_d  = 1'b1;
                    elem_d  = '0;
                    bit_d   = '0;
                end
            end
            S_DIVIDE: if (prep_q) begin
                prep_d = 1'b0;
            end else begin
                rem_d = rem_nxt;
                quo_d = quo_nxt;
                ovf_d = ovf_cur;
                if (bit_q == BIT_LAST) begin
                    bit_d = '0;
                    out_d[elem_q*DATA_W +: DATA_W] = sat_fn(quo_nxt, ovf_cur, neg);
                    if (elem_q == ELEM_LAST) state_d = S_OUTPUT;
                    else                     elem_d  = elem_q + 1'b1;
                end else begin
                    bit_d = bit_q + 1'b1;
                end
            end
            default: if (out_ready) state_d = S_IDLE;
        endcase
        if (clear) begin
            state_d = S_IDLE;
            m_d     = '0;
            l_d     = '0;
            have_d  = 1'b0;
            prep_d  = 1'b0;
            elem_d  = '0;
            bit_d   = '0;
            out_d   = '0;
            for (int i = 0; i < DIM; i++) o_d[i] = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            qv_q    <= '0;
            m_q     <= '0;
            l_q     <= '0;
            for (int i = 0; i < DIM; i++) o_q[i] <= '0;
            have_q  <= 1'b0;
            prep_q  <= 1'b0;
            elem_q  <= '0;
            bit_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            ovf_q   <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            qv_q    <= qv_d;
            m_q     <= m_d;
            l_q     <= l_d;
            o_q     <= o_d;
            have_q  <= have_d;
            prep_q  <= prep_d;
            elem_q  <= elem_d;
            bit_q   <= bit_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            ovf_q   <= ovf_d;
            out_q   <= out_d;
        end
    end

    assign q_ready   = (state_q == S_IDLE);
    assign kv_ready  = (state_q == S_ACCUM);
    assign out_valid = (state_q == S_OUTPUT);
    assign busy      = (state_q != S_IDLE);
    assign out_vec   = out_q;
endmodule
